// File: rtl/byte_serial_adder_32.sv
// 32-bit adder that reuses one 8-bit ripple-carry slice over four cycles,
// carrying between bytes in a register; start/busy/done handshake.

module rca_8_bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [8:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (a[i] & w_c[i]) | (b[i] & w_c[i]);
  end

  assign cout = w_c[8];

endmodule

module byte_serial_adder_32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic        busy,
  output logic        done,
  output logic [31:0] sum,
  output logic        cout,
  output logic        overflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_c;
  logic [1:0]  r_idx;
  logic [31:0] r_acc;

  logic [7:0]  w_a_byte;
  logic [7:0]  w_b_byte;
  logic [7:0]  w_sum_byte;
  logic        w_cout;
  logic [31:0] w_acc_next;

  assign w_a_byte = r_a[{r_idx, 3'b000} +: 8];
  assign w_b_byte = r_b[{r_idx, 3'b000} +: 8];

  rca_8_bit u_slice (
    .a    (w_a_byte),
    .b    (w_b_byte),
    .cin  (r_c),
    .sum  (w_sum_byte),
    .cout (w_cout)
  );

  // Accumulator with the current byte merged in; on the last pass this is the full result.
  always_comb begin
    w_acc_next = r_acc;
    w_acc_next[{r_idx, 3'b000} +: 8] = w_sum_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= 1'b0;
      r_idx    <= '0;
      r_acc    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_c     <= cin;
            r_idx   <= '0;
            busy    <= 1'b1;
            r_state <= S_ADD;
          end else begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_ADD: begin
          r_acc <= w_acc_next;
          r_c   <= w_cout;
          r_idx <= r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            sum      <= w_acc_next;
            cout     <= w_cout;
            overflow <= (r_a[31] == r_b[31]) & (w_sum_byte[7] != r_a[31]);
            busy     <= 1'b0;
            done     <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_serial_adder_32.sv
// Bench for byte_serial_adder_32: vector table, handshake corner cases and
// random operands checked against plain 33-bit arithmetic.

module tb_byte_serial_adder_32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [31:0] sum;
  logic        cout;
  logic        overflow;

  int n_pass  = 0;
  int n_total = 0;

  byte_serial_adder_32 dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] s;
    logic        c;
    logic        v;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Reference: unsigned add with carry, signed overflow from operand/result signs.
  task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic mc,
                       output logic [31:0] ms, output logic mco, output logic mv);
    logic [32:0] t;
    t   = {1'b0, ma} + {1'b0, mb} + {32'd0, mc};
    ms  = t[31:0];
    mco = t[32];
    mv  = (ma[31] == mb[31]) && (ms[31] != ma[31]);
  endtask

  // Raise start now, release just after the accepting edge, then scramble inputs.
  task automatic launch_now(input logic [31:0] oa, input logic [31:0] ob, input logic oc);
    start = 1'b1; a = oa; b = ob; cin = oc;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
  endtask

  task automatic start_op(input logic [31:0] oa, input logic [31:0] ob, input logic oc);
    @(posedge clk); #1;
    launch_now(oa, ob, oc);
  endtask

  // Returns at the negedge of the done cycle (bounded).
  task automatic wait_done(output int busy_cycles, output bit seen);
    busy_cycles = 0;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) busy_cycles++;
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [31:0] es,
                              input logic ec, input logic ev);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
    chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, ev});
  endtask

  initial begin
    int          bc;
    bit          seen;
    int          npulse;
    logic [31:0] ms;
    logic        mco;
    logic        mv;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;

    vecs[0] = '{32'h0000003F, 32'h00000055, 1'b0, 32'h00000094, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[3] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[4] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0};
    vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[6] = '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0, 1'b0};
    vecs[7] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      check_result("rst", 32'd0, 1'b0, 1'b0);
    end

    // Vector table
    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].cin);
      wait_done(bc, seen);
      chk($sformatf("vec%0d_busy_cycles", i), bc, 32'd4);
      check_result($sformatf("vec%0d", i), vecs[i].s, vecs[i].c, vecs[i].v);
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), {31'd0, done}, 32'd0);
      chk($sformatf("vec%0d_hold", i), sum, vecs[i].s);
    end

    // Back-to-back: second start asserted in the DONE cycle
    start_op(32'h7FFFFFFF, 32'h00000001, 1'b0);
    wait_done(bc, seen);
    check_result("b2b_first", 32'h80000000, 1'b0, 1'b1);
    launch_now(32'h80000000, 32'h80000000, 1'b0);
    wait_done(bc, seen);
    chk("b2b_busy_cycles", bc, 32'd4);
    check_result("b2b_second", 32'h00000000, 1'b1, 1'b1);

    // start during busy with new operands must be ignored
    start_op(32'h12345678, 32'h11111111, 1'b0);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    @(negedge clk);
    start = 1'b0;
    npulse = 0;
    for (int k = 0; k < 8; k++) begin
      if (done) begin
        npulse++;
        chk("ignore_sum", sum, 32'h23456789);
        chk("ignore_cout", {31'd0, cout}, 32'd0);
      end
      @(negedge clk);
    end
    chk("ignore_pulses", npulse, 32'd1);

    // Reset on the second ADD cycle aborts
    start_op(32'h000000FF, 32'h00000001, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    check_result("abort", 32'd0, 1'b0, 1'b0);
    npulse = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) npulse++;
    end
    chk("abort_no_done", npulse, 32'd0);
    start_op(32'd1, 32'd2, 1'b0);
    wait_done(bc, seen);
    check_result("after_abort", 32'h00000003, 1'b0, 1'b0);

    // Random operands, sometimes back-to-back
    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
      if (i % 8 == 3) ra = 32'h80000000 | ra;
      if (i % 8 == 3) rb = 32'h80000000 | rb;
      model(ra, rb, rc, ms, mco, mv);
      if (i % 3 == 0) launch_now(ra, rb, rc);
      else start_op(ra, rb, rc);
      wait_done(bc, seen);
      chk($sformatf("rnd%0d_busy_cycles", i), bc, 32'd4);
      check_result($sformatf("rnd%0d", i), ms, mco, mv);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
